// File: rtl/mdu_ctrl_if.sv
// Request/response handshake between the execute stage and the mul/div sequencer.
// The master side is the execute stage; the slave side is mdu_ctrl.
interface mdu_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Sequencer between execute and the iterative mul/div datapath, with a
// companion-result cache that answers div->rem / rem->div pairs without relaunching.
//
//  state | meaning
//  IDLE  | waiting for a request
//  BUSY  | op launched, waiting for mdu_done
//  DRAIN | op flushed while in flight, waiting for mdu_done to resync
//  HOLD  | result presented, waiting for the consumer
module mdu_ctrl #(
  parameter int XLEN    = 64,
  parameter bit FUSE_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  mdu_ctrl_if.slave       bus,
  output logic            mdu_start,
  output logic [2:0]      mdu_op,
  output logic [XLEN-1:0] mdu_src1,
  output logic [XLEN-1:0] mdu_src2,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_res,
  input  logic [XLEN-1:0] mdu_alt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] resp_data_q;

  logic            cache_valid;
  logic            cache_signed;
  logic [2:0]      cache_op;
  logic [XLEN-1:0] cache_src1;
  logic [XLEN-1:0] cache_src2;
  logic [XLEN-1:0] cache_alt;

  logic take_resp;
  logic req_ready_c;
  logic accept;
  logic cache_hit;
  logic cache_load;

  always_comb begin
    take_resp   = (state == ST_HOLD) && bus.resp_ready && !flush;
    req_ready_c = !flush && ((state == ST_IDLE) || take_resp);
    accept      = bus.req_valid && req_ready_c;
    // div/rem ops have op[2] set; the companion differs only in op[1]
    cache_hit   = FUSE_EN && cache_valid && bus.req_op[2]
                  && (cache_op == (bus.req_op ^ 3'b010))
                  && (cache_signed == !bus.req_op[0])
                  && (cache_src1 == bus.req_src1)
                  && (cache_src2 == bus.req_src2);
    cache_load  = FUSE_EN && mdu_done && mdu_op[2]
                  && ((state == ST_BUSY) || (state == ST_DRAIN));
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state == ST_HOLD);
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mdu_start   <= 1'b0;
      mdu_op      <= 3'd0;
      mdu_src1    <= '0;
      mdu_src2    <= '0;
      resp_data_q <= '0;
    end else begin
      mdu_start <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            mdu_op   <= bus.req_op;
            mdu_src1 <= bus.req_src1;
            mdu_src2 <= bus.req_src2;
            if (cache_hit) begin
              state       <= ST_HOLD;
              resp_data_q <= cache_alt;
            end else begin
              state     <= ST_BUSY;
              mdu_start <= 1'b1;
            end
          end else if ((state == ST_HOLD) && (flush || bus.resp_ready)) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            if (!flush) begin
              state       <= ST_HOLD;
              resp_data_q <= mdu_res;
            end else begin
              state <= ST_IDLE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mdu_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Loads even when the result itself is discarded by a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_op     <= 3'd0;
      cache_src1   <= '0;
      cache_src2   <= '0;
      cache_alt    <= '0;
    end else if (cache_load) begin
      cache_valid  <= 1'b1;
      cache_signed <= !mdu_op[0];
      cache_op     <= mdu_op;
      cache_src1   <= mdu_src1;
      cache_src2   <= mdu_src2;
      cache_alt    <= mdu_alt;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: one instance with the companion cache on, one with it off.
module tb_mdu_ctrl;
  localparam int XLEN = 64;
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MULH = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic [2:0]      req_op = 3'd0;
  logic [XLEN-1:0] req_src1 = '0;
  logic [XLEN-1:0] req_src2 = '0;
  logic            resp_ready = 1'b0;
  logic            mdu_done = 1'b0;
  logic [XLEN-1:0] mdu_res = '0;
  logic [XLEN-1:0] mdu_alt = '0;

  logic            start1, start0;
  logic [2:0]      op1, op0;
  logic [XLEN-1:0] a1, b1, a0, b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start1 = 0;
  int base;

  always #5 clock = ~clock;

  mdu_ctrl_if #(.XLEN(XLEN)) bus1 ();
  mdu_ctrl_if #(.XLEN(XLEN)) bus0 ();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_op     = req_op;
  assign bus1.req_src1   = req_src1;
  assign bus1.req_src2   = req_src2;
  assign bus1.resp_ready = resp_ready;
  assign bus0.req_valid  = req_valid;
  assign bus0.req_op     = req_op;
  assign bus0.req_src1   = req_src1;
  assign bus0.req_src2   = req_src2;
  assign bus0.resp_ready = resp_ready;

  mdu_ctrl #(.XLEN(XLEN), .FUSE_EN(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus1),
    .mdu_start(start1), .mdu_op(op1), .mdu_src1(a1), .mdu_src2(b1),
    .mdu_done(mdu_done), .mdu_res(mdu_res), .mdu_alt(mdu_alt)
  );

  mdu_ctrl #(.XLEN(XLEN), .FUSE_EN(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus0),
    .mdu_start(start0), .mdu_op(op0), .mdu_src1(a0), .mdu_src2(b0),
    .mdu_done(mdu_done), .mdu_res(mdu_res), .mdu_alt(mdu_alt)
  );

  always @(negedge clock) if (start1 === 1'b1) n_start1++;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                       input string tag);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    #1;
    check({tag, " req_ready"}, bus1.req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  // Called in the start cycle; pulses mdu_done lat cycles later.
  task automatic finish_op(input int lat, input logic [XLEN-1:0] res, input logic [XLEN-1:0] alt,
                           input string tag);
    for (int i = 0; i < lat; i++) step();
    check({tag, " busy resp_valid"}, bus1.resp_valid, 0);
    mdu_done = 1'b1;
    mdu_res  = res;
    mdu_alt  = alt;
    step();
    mdu_done = 1'b0;
    mdu_res  = 64'hdead;
    mdu_alt  = 64'hbeef;
  endtask

  task automatic take();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst resp_valid", bus1.resp_valid, 0);
    check("rst resp_data", bus1.resp_data, 0);
    check("rst mdu_start", start1, 0);
    check("rst mdu_op", op1, 0);
    check("rst mdu_src1", a1, 0);
    reset = 1'b0;
    #1;
    check("rst req_ready", bus1.req_ready, 1);
    step();

    // reset mid-BUSY
    issue(OP_MUL, 2, 3, "s1");
    check("s1 start", start1, 1);
    check("s1 src1", a1, 2);
    step();
    check("s1 start one cycle", start1, 0);
    reset = 1'b1;
    #1;
    check("s1 async resp_valid", bus1.resp_valid, 0);
    check("s1 async start", start1, 0);
    check("s1 async src1", a1, 0);
    reset = 1'b0;
    step();
    check("s1 idle req_ready", bus1.req_ready, 1);

    // div 100/7, latency 5, delayed consumer
    base = n_start1;
    issue(OP_DIV, 100, 7, "s2");
    check("s2 start", start1, 1);
    check("s2 op", op1, OP_DIV);
    check("s2 src2", b1, 7);
    check("s2 busy ready", bus1.req_ready, 0);
    finish_op(5, 14, 2, "s2");
    check("s2 resp_valid", bus1.resp_valid, 1);
    check("s2 resp_data", bus1.resp_data, 14);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s2 hold valid", bus1.resp_valid, 1);
      check("s2 hold data", bus1.resp_data, 14);
    end
    take();
    check("s2 released", bus1.resp_valid, 0);
    check("s2 start count", n_start1 - base, 1);

    // companion hit, then unsigned miss
    base = n_start1;
    issue(OP_REM, 100, 7, "s3");
    check("s3 hit valid", bus1.resp_valid, 1);
    check("s3 hit data", bus1.resp_data, 2);
    check("s3 hit no start", start1, 0);
    take();
    issue(OP_REMU, 100, 7, "s3u");
    check("s3u start", start1, 1);
    finish_op(1, 2, 14, "s3u");
    check("s3u data", bus1.resp_data, 2);
    take();
    check("s3 start count", n_start1 - base, 1);

    // flush mid-mulh -> DRAIN
    issue(OP_MULH, 9, 9, "s4");
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b1;
    req_op = OP_MUL;
    req_src1 = 6;
    req_src2 = 7;
    #1;
    check("s4 drain ready", bus1.req_ready, 0);
    check("s4 drain valid", bus1.resp_valid, 0);
    step();
    mdu_done = 1'b1;
    mdu_res = 81;
    flush = 1'b1;
    #1;
    check("s4 done ready", bus1.req_ready, 0);
    step();
    mdu_done = 1'b0;
    flush = 1'b0;
    #1;
    check("s4 discarded", bus1.resp_valid, 0);
    check("s4 after done ready", bus1.req_ready, 1);
    step();
    req_valid = 1'b0;
    check("s4 next start", start1, 1);
    check("s4 next src1", a1, 6);
    finish_op(1, 42, 0, "s4n");
    check("s4 next data", bus1.resp_data, 42);
    take();

    // flush coinciding with done; cache still loads
    issue(OP_DIVU, 50, 5, "s5");
    step();
    mdu_done = 1'b1;
    flush = 1'b1;
    mdu_res = 10;
    mdu_alt = 64'h33;
    step();
    mdu_done = 1'b0;
    flush = 1'b0;
    #1;
    check("s5 no resp", bus1.resp_valid, 0);
    check("s5 idle ready", bus1.req_ready, 1);
    step();
    check("s5 still no resp", bus1.resp_valid, 0);
    issue(OP_REMU, 50, 5, "s5h");
    check("s5 hit valid", bus1.resp_valid, 1);
    check("s5 hit data", bus1.resp_data, 64'h33);
    check("s5 hit no start", start1, 0);
    flush = 1'b1;
    resp_ready = 1'b1;
    req_valid = 1'b1;
    #1;
    check("s5 flush ready", bus1.req_ready, 0);
    step();
    flush = 1'b0;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check("s5 hold dropped", bus1.resp_valid, 0);
    check("s5 flush no start", start1, 0);
    mdu_done = 1'b1;
    mdu_res = 64'h99;
    step();
    mdu_done = 1'b0;
    check("s5 stray done", bus1.resp_valid, 0);

    // back-to-back through HOLD
    issue(OP_MUL, 2, 4, "s6");
    finish_op(1, 8, 0, "s6");
    check("s6 first data", bus1.resp_data, 8);
    resp_ready = 1'b1;
    req_valid = 1'b1;
    req_op = OP_MUL;
    req_src1 = 3;
    req_src2 = 5;
    #1;
    check("s6 hold ready", bus1.req_ready, 1);
    step();
    req_valid = 1'b0;
    resp_ready = 1'b0;
    check("s6 start", start1, 1);
    check("s6 src1", a1, 3);
    check("s6 src2", b1, 5);
    check("s6 busy valid", bus1.resp_valid, 0);
    finish_op(1, 15, 0, "s6b");
    check("s6 second valid", bus1.resp_valid, 1);
    check("s6 second data", bus1.resp_data, 15);
    take();

    // cache disabled: rem relaunches
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req_valid = 1'b1;
    req_op = OP_DIV;
    req_src1 = 100;
    req_src2 = 7;
    #1;
    check("s7 div ready", bus0.req_ready, 1);
    step();
    req_valid = 1'b0;
    check("s7 div start", start0, 1);
    finish_op(1, 14, 2, "s7");
    check("s7 div data", bus0.resp_data, 14);
    take();
    req_valid = 1'b1;
    req_op = OP_REM;
    #1;
    check("s7 rem ready", bus0.req_ready, 1);
    step();
    req_valid = 1'b0;
    check("s7 rem start", start0, 1);
    check("s7 rem pending", bus0.resp_valid, 0);
    check("s7 fused hit", bus1.resp_valid, 1);
    check("s7 fused no start", start1, 0);
    mdu_done = 1'b1;
    mdu_res = 2;
    step();
    mdu_done = 1'b0;
    check("s7 rem valid", bus0.resp_valid, 1);
    check("s7 rem data", bus0.resp_data, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
